// File: rtl/enet_pkg.sv
// enet_pkg: shared definitions for the Ethernet PHY reset sequencer.
//   - default parameter values for enet_phy_reset
//   - FSM state enum
//   - max3() helper used to size the shared down-counter
package enet_pkg;

  localparam int unsigned ENET_NUM_PHY_DEF       = 1;
  localparam int unsigned ENET_RESET_CYCLES_DEF  = 1024;
  localparam int unsigned ENET_SETTLE_CYCLES_DEF = 256;
  localparam int unsigned ENET_STRAP_HOLD_DEF    = 16;
  localparam int unsigned ENET_STRAP_W_DEF       = 4;
  localparam int unsigned ENET_SEQ_W             = 8;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  // Largest of three phase lengths; sizes the shared counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/enet_phy_reset.sv
// enet_phy_reset: power-up / software-requested reset sequencer for up to
// eight Ethernet PHYs. Sequence: ASSERT (reset low) -> HOLD (straps still
// driven) -> SETTLE -> READY, with one shared down-counter timing each phase.
//
// Configuration macro: ENET_PHY_STRAP_EN
//   defined   : straps latched per sequence and driven through ASSERT/HOLD
//   undefined : HOLD skipped, strap_o / strap_oe_o tied 0, strap_cfg_i unused
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset (aborts any sequence)
//   rst_req_i      software reset request pulse (honoured only in READY)
//   rst_mask_i     PHYs to reset on a software request
//   strap_cfg_i    strap values latched at the start of each sequence
//   phy_reset_n_o  active-low PHY resets
//   strap_o        strap bus value
//   strap_oe_o     strap bus output enable
//   busy_o         sequence in progress
//   ready_o        idle, ~busy_o
//   done_o         one-clock pulse on sequence completion
//   seq_count_o    completed sequences, saturating at 255
module enet_phy_reset
  import enet_pkg::*;
#(
  parameter int unsigned NUM_PHY       = ENET_NUM_PHY_DEF,
  parameter int unsigned RESET_CYCLES  = ENET_RESET_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = ENET_SETTLE_CYCLES_DEF,
  parameter int unsigned STRAP_HOLD    = ENET_STRAP_HOLD_DEF,
  parameter int unsigned STRAP_W       = ENET_STRAP_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rst_req_i,
  input  logic [NUM_PHY-1:0]    rst_mask_i,
  input  logic [STRAP_W-1:0]    strap_cfg_i,
  output logic [NUM_PHY-1:0]    phy_reset_n_o,
  output logic [STRAP_W-1:0]    strap_o,
  output logic                  strap_oe_o,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [ENET_SEQ_W-1:0] seq_count_o
);

  localparam int unsigned CNT_MAX = max3(RESET_CYCLES, SETTLE_CYCLES, STRAP_HOLD);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_PHY-1:0]      mask_q, mask_d;
  logic [NUM_PHY-1:0]      phy_n_q, phy_n_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic [ENET_SEQ_W-1:0]   seq_q, seq_d;
  logic [STRAP_W-1:0]      strap_q, strap_d;
  logic                    oe_q, oe_d;
  logic                    cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(1));

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= CNT_W'(RESET_CYCLES);
      mask_q  <= '1;
      phy_n_q <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      seq_q   <= '0;
      strap_q <= '0;
`ifdef ENET_PHY_STRAP_EN
      oe_q    <= 1'b1;
`else
      oe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      phy_n_q <= phy_n_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      seq_q   <= seq_d;
      strap_q <= strap_d;
      oe_q    <= oe_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    phy_n_d = phy_n_q;
    done_d  = 1'b0;
    seq_d   = seq_q;
    strap_d = strap_q;

    unique case (state_q)
      ST_ASSERT: begin
        phy_n_d = ~mask_q;
`ifdef ENET_PHY_STRAP_EN
        // Counter still full means this is the first ASSERT clock.
        if (cnt_q == CNT_W'(RESET_CYCLES)) strap_d = strap_cfg_i;
`endif
        if (cnt_last) begin
          phy_n_d = '1;
`ifdef ENET_PHY_STRAP_EN
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(STRAP_HOLD);
`else
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        phy_n_d = '1;
        if (cnt_last) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_last) begin
          state_d = ST_READY;
          done_d  = 1'b1;
          strap_d = '0;
          seq_d   = (seq_q == '1) ? seq_q : seq_q + ENET_SEQ_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READY: begin
        if (rst_req_i && (|rst_mask_i)) begin
          state_d = ST_ASSERT;
          cnt_d   = CNT_W'(RESET_CYCLES);
          mask_d  = rst_mask_i;
          phy_n_d = ~rst_mask_i;
        end
      end
      default: ;
    endcase

    busy_d  = (state_d != ST_READY);
    ready_d = ~busy_d;
`ifdef ENET_PHY_STRAP_EN
    oe_d    = (state_d == ST_ASSERT) || (state_d == ST_HOLD);
`else
    oe_d    = 1'b0;
`endif
  end

`ifdef ENET_PHY_STRAP_EN
  assign strap_o    = strap_q;
  assign strap_oe_o = oe_q;
`else
  logic unused_strap;
  assign unused_strap = (^strap_cfg_i) ^ (^strap_q) ^ oe_q;
  assign strap_o      = '0;
  assign strap_oe_o   = 1'b0;
`endif

  assign phy_reset_n_o = phy_n_q;
  assign busy_o        = busy_q;
  assign ready_o       = ready_q;
  assign done_o        = done_q;
  assign seq_count_o   = seq_q;

endmodule

// File: tb/tb_enet_phy_reset.sv
// Bench for enet_phy_reset (NUM_PHY=2, RESET_CYCLES=8, STRAP_HOLD=2,
// SETTLE_CYCLES=4). Reference: sequence position counted from its start;
// every output is a plain function of that position.
module tb_enet_phy_reset;

  localparam int unsigned NP = 2;
  localparam int unsigned RC = 8;
  localparam int unsigned SH = 2;
  localparam int unsigned SC = 4;
  localparam int unsigned SW = 4;
`ifdef ENET_PHY_STRAP_EN
  localparam bit          STRAP_EN = 1'b1;
  localparam int unsigned HOLD_EFF = SH;
`else
  localparam bit          STRAP_EN = 1'b0;
  localparam int unsigned HOLD_EFF = 0;
`endif
  localparam int unsigned TOTAL = RC + HOLD_EFF + SC;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          rst_req_i = 1'b0;
  logic [NP-1:0] rst_mask_i = '0;
  logic [SW-1:0] strap_cfg_i = 4'hA;
  logic [NP-1:0] phy_reset_n_o;
  logic [SW-1:0] strap_o;
  logic          strap_oe_o;
  logic          busy_o;
  logic          ready_o;
  logic          done_o;
  logic [7:0]    seq_count_o;

  int checks = 0;
  int passes = 0;

  enet_phy_reset #(
    .NUM_PHY(NP), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC),
    .STRAP_HOLD(SH), .STRAP_W(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rst_req_i(rst_req_i),
    .rst_mask_i(rst_mask_i), .strap_cfg_i(strap_cfg_i),
    .phy_reset_n_o(phy_reset_n_o), .strap_o(strap_o),
    .strap_oe_o(strap_oe_o), .busy_o(busy_o), .ready_o(ready_o),
    .done_o(done_o), .seq_count_o(seq_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: position within the current sequence.
  int unsigned   m_pos   = 0;
  logic [NP-1:0] m_mask  = '1;
  logic [SW-1:0] m_strap = '0;
  int unsigned   m_cnt   = 0;
  logic          m_done  = 1'b0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_pos = 0; m_mask = '1; m_strap = '0; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pos < TOTAL) begin
        if (m_pos == 0) m_strap = strap_cfg_i;
        m_pos++;
        if (m_pos == TOTAL) begin
          m_done = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (rst_req_i && (rst_mask_i != '0)) begin
        m_pos  = 0;
        m_mask = rst_mask_i;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk_i) begin
    logic [NP-1:0] e_phy;
    logic [SW-1:0] e_strap;
    #1;
    e_phy   = (m_pos < RC) ? ~m_mask : '1;
    e_strap = (STRAP_EN && m_pos >= 1 && m_pos < TOTAL) ? m_strap : '0;
    check("cyc_phy_reset_n", 32'(phy_reset_n_o), 32'(e_phy));
    check("cyc_busy", 32'(busy_o), 32'(m_pos < TOTAL));
    check("cyc_ready", 32'(ready_o), 32'(m_pos >= TOTAL));
    check("cyc_done", 32'(done_o), 32'(m_done));
    check("cyc_seq_count", 32'(seq_count_o), 32'(m_cnt));
    check("cyc_strap", 32'(strap_o), 32'(e_strap));
    check("cyc_strap_oe", 32'(strap_oe_o), 32'(STRAP_EN && (m_pos < RC + HOLD_EFF)));
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready_o !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("wait_ready_timeout", 32'(ready_o), 32'd1);
  endtask

  task automatic request(input logic [NP-1:0] mask);
    @(negedge clk_i);
    rst_req_i  = 1'b1;
    rst_mask_i = mask;
    step();
    @(negedge clk_i);
    rst_req_i  = 1'b0;
    rst_mask_i = '0;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_phy", 32'(phy_reset_n_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_seq", 32'(seq_count_o), 32'd0);
    check("rst_strap", 32'(strap_o), 32'h0);
    check("rst_oe", 32'(strap_oe_o), 32'(STRAP_EN));

    // Power-up sequence.
    rst_i = 1'b0;
    for (int k = 1; k <= int'(TOTAL); k++) begin
      step();
      if (k == 1) check("pu_strap", 32'(strap_o), STRAP_EN ? 32'hA : 32'h0);
      if (k == int'(RC) - 1) check("pu_phy_low", 32'(phy_reset_n_o), 32'h0);
      if (k == int'(RC)) check("pu_phy_high", 32'(phy_reset_n_o), 32'h3);
      if (k == int'(RC + HOLD_EFF) - 1) check("pu_oe_last", 32'(strap_oe_o), 32'(STRAP_EN));
      if (k == int'(RC + HOLD_EFF)) check("pu_oe_off", 32'(strap_oe_o), 32'd0);
      if (k == int'(TOTAL) - 1) check("pu_done_early", 32'(done_o), 32'd0);
    end
    check("pu_done", 32'(done_o), 32'd1);
    check("pu_seq", 32'(seq_count_o), 32'd1);
    step();
    check("pu_done_pulse", 32'(done_o), 32'd0);

    // Masked software request: PHY1 only.
    @(negedge clk_i);
    rst_req_i = 1'b1; rst_mask_i = 2'b10;
    for (int k = 1; k <= int'(RC) + 1; k++) begin
      step();
      if (k == 1) begin
        @(negedge clk_i);
        rst_req_i = 1'b0; rst_mask_i = '0;
        check("mask_phy_first", 32'(phy_reset_n_o), 32'h1);
      end else if (k <= int'(RC)) begin
        check("mask_phy0_high", 32'(phy_reset_n_o), 32'h1);
      end else begin
        check("mask_phy_release", 32'(phy_reset_n_o), 32'h3);
      end
    end
    wait_ready(40);
    check("mask_seq", 32'(seq_count_o), 32'd2);

    // Request during SETTLE is ignored; done timing unchanged.
    request(2'b01);
    for (int k = 2; k <= int'(RC + HOLD_EFF) + 2; k++) step();
    @(negedge clk_i);
    rst_req_i = 1'b1; rst_mask_i = 2'b11;
    step();
    @(negedge clk_i);
    rst_req_i = 1'b0; rst_mask_i = '0;
    for (int k = int'(RC + HOLD_EFF) + 4; k <= int'(TOTAL) + 1; k++) step();
    check("ign_done", 32'(done_o), 32'd1);
    check("ign_seq", 32'(seq_count_o), 32'd3);
    // Zero mask in READY is ignored.
    @(negedge clk_i);
    rst_req_i = 1'b1; rst_mask_i = 2'b00;
    step();
    @(negedge clk_i);
    rst_req_i = 1'b0;
    check("zero_ready", 32'(ready_o), 32'd1);
    check("zero_phy", 32'(phy_reset_n_o), 32'h3);
    step();
    check("zero_seq", 32'(seq_count_o), 32'd3);

    // Reset mid-ASSERT, then full-length restart.
    request(2'b11);
    repeat (4) step();
    #2 rst_i = 1'b1;
    #1;
    check("mid_phy", 32'(phy_reset_n_o), 32'h0);
    check("mid_busy", 32'(busy_o), 32'd1);
    check("mid_ready", 32'(ready_o), 32'd0);
    check("mid_seq", 32'(seq_count_o), 32'd0);
    check("mid_strap", 32'(strap_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 1; k <= int'(RC); k++) begin
      step();
      if (k < int'(RC)) check("mid_phy_low", 32'(phy_reset_n_o), 32'h0);
      else check("mid_phy_high", 32'(phy_reset_n_o), 32'h3);
    end
    wait_ready(40);

    // Saturation: 256 more sequences after the power-up one.
    for (int i = 0; i < 256; i++) begin
      strap_cfg_i = 4'($urandom);
      request(2'($urandom_range(1, 3)));
      wait_ready(40);
    end
    check("sat_seq", 32'(seq_count_o), 32'd255);
    request(2'b01);
    wait_ready(40);
    check("sat_hold", 32'(seq_count_o), 32'd255);

    // Random traffic including occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      rst_i       = ($urandom_range(0, 149) == 0);
      rst_req_i   = ($urandom_range(0, 3) == 0);
      rst_mask_i  = 2'($urandom);
      strap_cfg_i = 4'($urandom);
    end
    @(negedge clk_i);
    rst_i = 1'b0; rst_req_i = 1'b0; rst_mask_i = '0;
    repeat (30) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
